// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: each channel emits a one-cycle
// tick every D cycles and, in mode 1, a 50%-duty square wave of period 2*D.
module clk_enable_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                                          clk_in,
  input  logic                                          reset_n,
  input  logic [NUM_CH-1:0]                             ch_en,
  input  logic                                          sync_all,
  input  logic                                          cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  input  logic                                          cfg_mode,
  output logic [NUM_CH-1:0]                             tick,
  output logic [NUM_CH-1:0]                             div_out,
  output logic [NUM_CH-1:0]                             cfg_pending
);

  localparam logic [CNT_W-1:0] RST_DIV =
    (DEFAULT_DIV < 2) ? CNT_W'(2) : CNT_W'(DEFAULT_DIV);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  act_div [NUM_CH];
  logic [CNT_W-1:0]  shd_div [NUM_CH];
  logic [NUM_CH-1:0] act_mode;
  logic [NUM_CH-1:0] shd_mode;

  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] hit;

  // Config writes have no back-pressure: every cfg_we cycle is accepted, and a
  // write to a channel that is still pending simply replaces its shadow.
  always_comb begin
    wrap  = '0;
    apply = '0;
    hit   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i]  = ch_en[i] && (cnt[i] == act_div[i] - CNT_W'(1));
      apply[i] = cfg_pending[i] && (sync_all || !ch_en[i] || wrap[i]);
      hit[i]   = cfg_we && (int'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        act_div[i] <= RST_DIV;
        shd_div[i] <= RST_DIV;
      end
      act_mode    <= '0;
      shd_mode    <= '0;
      tick        <= '0;
      div_out     <= '0;
      cfg_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_all || !ch_en[i]) begin
          cnt[i]     <= '0;
          tick[i]    <= 1'b0;
          div_out[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          // The wrap belongs to the old period, so the toggle follows the old mode;
          // switching to mode 0 parks the square output low.
          if (apply[i] && !shd_mode[i])
            div_out[i] <= 1'b0;
          else if (act_mode[i])
            div_out[i] <= ~div_out[i];
        end else begin
          cnt[i]  <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
        end

        if (apply[i]) begin
          act_div[i]     <= shd_div[i];
          act_mode[i]    <= shd_mode[i];
          cfg_pending[i] <= 1'b0;
        end
        // A write landing on the apply edge stays in the shadow for the next wrap.
        if (hit[i]) begin
          shd_div[i]     <= clamp_div(cfg_div);
          shd_mode[i]    <= cfg_mode;
          cfg_pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: a 4-channel instance for the main scenarios and
// a 3-channel instance where an out-of-range channel index exists.
module tb_clk_enable_gen;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [3:0]  ch_en;
  logic        sync_all;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  tick;
  logic [3:0]  div_out;
  logic [3:0]  cfg_pending;

  logic [2:0]  ch_en3;
  logic        sync3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [7:0]  cfg_div3;
  logic        cfg_mode3;
  logic [2:0]  tick3;
  logic [2:0]  div3;
  logic [2:0]  pend3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [3:0] et;

  always #5 clk_in = ~clk_in;

  clk_enable_gen #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(4)) u_dut (
    .clk_in(clk_in), .reset_n(reset_n), .ch_en(ch_en), .sync_all(sync_all),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .tick(tick), .div_out(div_out), .cfg_pending(cfg_pending)
  );

  clk_enable_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) u_dut3 (
    .clk_in(clk_in), .reset_n(reset_n), .ch_en(ch_en3), .sync_all(sync3),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .cfg_mode(cfg_mode3),
    .tick(tick3), .div_out(div3), .cfg_pending(pend3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; cyc numbers that edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d, input logic m);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = d;
    cfg_mode = m;
  endtask

  initial begin
    reset_n  = 1'b0;
    ch_en    = 4'b0001;
    sync_all = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_mode = 1'b0;
    ch_en3    = 3'b001;
    sync3     = 1'b0;
    cfg_we3   = 1'b0;
    cfg_ch3   = '0;
    cfg_div3  = '0;
    cfg_mode3 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_tick", tick, 4'b0000);
    chk("rst_div", div_out, 4'b0000);
    chk("rst_pend", cfg_pending, 4'b0000);
    chk("rst_tick3", tick3, 3'b000);
    reset_n = 1'b1;
    cyc = 0;

    // Default D=4 on ch0: ticks after edges 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("def_tick", tick, (k % 4 == 0) ? 4'b0001 : 4'b0000);
      chk("def_div", div_out, 4'b0000);
      chk("def_pend", cfg_pending, 4'b0000);
      chk("def_tick3", tick3, (k % 3 == 0) ? 3'b001 : 3'b000);
    end

    // ch1 runs at D=4, then D=10 mode 1 written mid-count lands at the edge-20 wrap
    ch_en = 4'b0011;
    for (int k = 13; k <= 50; k++) begin
      if (cyc == 17) wr(2'd1, 16'd10, 1'b1);
      if (cyc == 18) cfg_we = 1'b0;
      step();
      et[0] = (k % 4 == 0);
      et[1] = (k <= 20) ? (k % 4 == 0) : (k % 10 == 0);
      chk("rp_tick", tick[1:0], et[1:0]);
      chk("rp_div1", div_out[1], (k >= 30 && k < 40) || k == 50);
      chk("rp_div0", div_out[0], 1'b0);
      chk("rp_pend1", cfg_pending[1], (k >= 18 && k < 20));
    end

    // D=0 clamps to 2; applied at the edge-60 wrap of the D=10 period
    for (int k = 51; k <= 70; k++) begin
      if (cyc == 50) wr(2'd1, 16'd0, 1'b1);
      if (cyc == 51) cfg_we = 1'b0;
      step();
      chk("cl_tick1", tick[1], (k >= 60 && k % 2 == 0));
      chk("cl_div1", div_out[1], (k < 60) ? 1'b1 : (((k - 60) / 2) % 2 == 1));
      chk("cl_pend1", cfg_pending[1], (k >= 51 && k < 60));
      chk("cl_tick0", tick[0], (k % 4 == 0));
    end

    // ch2: D=3 pending, D=6 written on the edge-74 wrap
    for (int k = 71; k <= 90; k++) begin
      if (cyc == 70) ch_en = 4'b0111;
      if (cyc == 71) wr(2'd2, 16'd3, 1'b0);
      if (cyc == 72) cfg_we = 1'b0;
      if (cyc == 73) wr(2'd2, 16'd6, 1'b0);
      if (cyc == 74) cfg_we = 1'b0;
      step();
      chk("ww_tick2", tick[2], (k == 74 || k == 77 || k == 83 || k == 89));
      chk("ww_pend2", cfg_pending[2], (k >= 72 && k < 77));
      chk("ww_div2", div_out[2], 1'b0);
      chk("ww_tick1", tick[1], (k % 2 == 0));
      chk("ww_div1", div_out[1], (((k - 60) / 2) % 2 == 1));
    end

    // Program D=3,5,7,9, then sync at edge 95
    for (int k = 91; k <= 95; k++) begin
      if (cyc == 90) wr(2'd0, 16'd3, 1'b0);
      if (cyc == 91) wr(2'd1, 16'd5, 1'b0);
      if (cyc == 92) wr(2'd2, 16'd7, 1'b0);
      if (cyc == 93) wr(2'd3, 16'd9, 1'b0);
      if (cyc == 94) begin
        cfg_we   = 1'b0;
        ch_en    = 4'b1111;
        sync_all = 1'b1;
      end
      step();
    end
    sync_all = 1'b0;
    chk("sy_tick", tick, 4'b0000);
    chk("sy_div", div_out, 4'b0000);
    chk("sy_pend", cfg_pending, 4'b0000);
    for (int k = 96; k <= 410; k++) begin
      step();
      et = {((k - 95) % 9 == 0), ((k - 95) % 7 == 0), ((k - 95) % 5 == 0), ((k - 95) % 3 == 0)};
      chk("sy_phase", tick, et);
      chk("sy_div0", div_out, 4'b0000);
    end
    chk("sy_all_315", tick, 4'b1111);

    // ch0 disabled for edges 412-413 with a D=5 mode-1 write pending; invalid write on u_dut3
    for (int k = 411; k <= 432; k++) begin
      if (cyc == 410) wr(2'd0, 16'd5, 1'b1);
      if (cyc == 411) begin
        cfg_we = 1'b0;
        ch_en  = 4'b1110;
      end
      if (cyc == 413) ch_en = 4'b1111;
      if (cyc == 419) begin
        cfg_we3   = 1'b1;
        cfg_ch3   = 2'd3;
        cfg_div3  = 8'd7;
        cfg_mode3 = 1'b1;
      end
      if (cyc == 420) cfg_we3 = 1'b0;
      step();
      chk("en_tick0", tick[0], (k == 418 || k == 423 || k == 428));
      chk("en_div0", div_out[0], (k >= 418 && k < 423) || k >= 428);
      chk("en_pend0", cfg_pending[0], (k == 411));
      chk("inv_tick3", tick3, (k % 3 == 0) ? 3'b001 : 3'b000);
      chk("inv_div3", div3, 3'b000);
      chk("inv_pend3", pend3, 3'b000);
    end

    // Pending write on ch1, then asynchronous reset mid-period
    for (int k = 433; k <= 438; k++) begin
      if (cyc == 435) wr(2'd1, 16'd20, 1'b1);
      if (cyc == 436) cfg_we = 1'b0;
      step();
    end
    chk("pre_pend1", cfg_pending[1], 1'b1);
    chk("pre_div0", div_out[0], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_tick", tick, 4'b0000);
    chk("ar_div", div_out, 4'b0000);
    chk("ar_pend", cfg_pending, 4'b0000);
    repeat (2) @(posedge clk_in);
    #1;
    chk("ar_hold_pend", cfg_pending, 4'b0000);
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("ar_def_tick", tick, (k % 4 == 0) ? 4'b1111 : 4'b0000);
      chk("ar_def_div", div_out, 4'b0000);
      chk("ar_def_pend", cfg_pending, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
